// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces presses and releases, pulses key_valid once per accepted press and
// keeps the last four accepted key codes as a four-digit entry register.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   row_n      keypad rows, active-low, asynchronous to clk
//   clear      synchronous clear of hex3..hex0 (wins over a same-cycle key_valid)
//   col_n      column drive, active-low, exactly one bit low
//   key_valid  one-cycle pulse per accepted press
//   key_code   {row_idx, col_idx} of the last accepted press
//   key_held   high while the accepted key is still down (PRESSED or RELEASE)
//   hex3..hex0 entry register, hex0 is the newest digit
module hex_keypad_scanner #(
    parameter int unsigned SCAN_DIV = 16,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    input  logic       clear,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic [3:0] hex3,
    output logic [3:0] hex2,
    output logic [3:0] hex1,
    output logic [3:0] hex0
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TGT  = CNT_W'(DEBOUNCE);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DEBOUNCE = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_RELEASE  = 2'd3;

    // Lowest-numbered active row in a row pattern.
    function automatic logic [1:0] lowest_row(input logic [3:0] pat);
        logic [1:0] idx;
        if (pat[0])      idx = 2'd0;
        else if (pat[1]) idx = 2'd1;
        else if (pat[2]) idx = 2'd2;
        else             idx = 2'd3;
        return idx;
    endfunction

    // Active-low one-cold column drive for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] drv;
        case (idx)
            2'd0:    drv = 4'b1110;
            2'd1:    drv = 4'b1101;
            2'd2:    drv = 4'b1011;
            default: drv = 4'b0111;
        endcase
        return drv;
    endfunction

    logic [3:0]       sync1_q;
    logic [3:0]       rows_s_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cap_q, cap_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_n_q, col_n_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_held_q, key_held_d;
    logic [3:0][3:0]  digits_q, digits_d;

    logic             sample_c;
    logic [3:0]       pattern_c;
    logic [CNT_W-1:0] cnt_inc_c;

    assign sample_c  = (div_q == DIV_LAST);
    assign pattern_c = ~rows_s_q;
    assign cnt_inc_c = cnt_q + CNT_ONE;

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 4'b1111;
            rows_s_q <= 4'b1111;
        end else begin
            sync1_q  <= row_n;
            rows_s_q <= sync1_q;
        end
    end

    // Free-running slot divider; one row sample at the end of each slot.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (sample_c) begin
            div_d = '0;
        end
    end

    // Scan / debounce state machine.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        col_idx_d   = col_idx_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;

        case (state_q)
            S_IDLE: begin
                if (sample_c) begin
                    if (pattern_c == 4'b0000) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        cap_d = pattern_c;
                        cnt_d = CNT_ONE;
                        if (CNT_ONE == CNT_TGT) begin
                            state_d     = S_PRESSED;
                            key_valid_d = 1'b1;
                            key_code_d  = {lowest_row(pattern_c), col_idx_q};
                        end else begin
                            state_d = S_DEBOUNCE;
                        end
                    end
                end
            end

            S_DEBOUNCE: begin
                if (sample_c) begin
                    if (pattern_c == cap_q) begin
                        cnt_d = cnt_inc_c;
                        if (cnt_inc_c == CNT_TGT) begin
                            state_d     = S_PRESSED;
                            key_valid_d = 1'b1;
                            key_code_d  = {lowest_row(cap_q), col_idx_q};
                        end
                    end else begin
                        // Bounce or a different pattern: abandon and move on.
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end

            S_PRESSED: begin
                // Pattern changes within the frozen column are ignored.
                if (sample_c && (pattern_c == 4'b0000)) begin
                    cnt_d = CNT_ONE;
                    if (CNT_ONE == CNT_TGT) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        state_d = S_RELEASE;
                    end
                end
            end

            default: begin
                if (sample_c) begin
                    if (pattern_c == 4'b0000) begin
                        cnt_d = cnt_inc_c;
                        if (cnt_inc_c == CNT_TGT) begin
                            state_d   = S_IDLE;
                            cnt_d     = '0;
                            col_idx_d = col_idx_q + 2'd1;
                        end
                    end else begin
                        // Release bounce: still the same key, no new pulse.
                        state_d = S_PRESSED;
                    end
                end
            end
        endcase
    end

    // Registered output images of the next state.
    always_comb begin
        col_n_d    = col_drive(col_idx_d);
        key_held_d = (state_d == S_PRESSED) || (state_d == S_RELEASE);
    end

    // Entry register: clear beats a same-cycle key_valid.
    always_comb begin
        digits_d = digits_q;
        if (clear) begin
            digits_d = '0;
        end else if (key_valid_q) begin
            digits_d = {digits_q[2], digits_q[1], digits_q[0], key_code_q};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q       <= '0;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cap_q       <= 4'b0000;
            col_idx_q   <= 2'd0;
            col_n_q     <= 4'b1110;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
            digits_q    <= '0;
        end else begin
            div_q       <= div_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            col_idx_q   <= col_idx_d;
            col_n_q     <= col_n_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            digits_q    <= digits_d;
        end
    end

    assign col_n     = col_n_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;
    assign hex3      = digits_q[3];
    assign hex2      = digits_q[2];
    assign hex1      = digits_q[1];
    assign hex0      = digits_q[0];

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Directed bench for hex_keypad_scanner with SCAN_DIV=4, DEBOUNCE=3.
// A keypad model pulls a row low while its pressed key's column is driven.
module tb_hex_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] row_n;
    logic       clear;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic [3:0] hex3, hex2, hex1, hex0;

    logic [15:0] key_mask;
    int          total = 0;
    int          bad   = 0;
    int          kv_cnt = 0;
    int          kv0;

    hex_keypad_scanner #(
        .SCAN_DIV (4),
        .DEBOUNCE (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_n     (row_n),
        .clear     (clear),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held),
        .hex3      (hex3),
        .hex2      (hex2),
        .hex1      (hex1),
        .hex0      (hex0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keypad: bit (row*4+col) of key_mask is a pressed key.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_mask[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // After this returns, the next rising edge is edge 1 out of reset.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_kv(input int maxc, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(posedge clk);
            #1;
            if (key_valid) got = 1'b1;
        end
        check_eq(tag, 16'(got), 16'd1);
    endtask

    task automatic wait_release(input int maxc, input string tag);
        bit got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(posedge clk);
            #1;
            if (!key_held) got = 1'b1;
        end
        check_eq(tag, 16'(got), 16'd1);
    endtask

    task automatic press_key(input logic [3:0] code);
        key_mask = 16'h0001 << code;
        wait_kv(80, "t3_kv_wait");
        check_eq("t3_code", 16'(key_code), 16'(code));
        step(10);
        key_mask = 16'h0000;
        wait_release(60, "t3_rel_wait");
        step(5);
    endtask

    initial begin
        reset    = 1'b0;
        clear    = 1'b0;
        key_mask = 16'h0000;

        // Reset state
        step(3);
        check_eq("rst_col",  16'(col_n), 16'h000E);
        check_eq("rst_kv",   16'(key_valid), 16'd0);
        check_eq("rst_code", 16'(key_code), 16'd0);
        check_eq("rst_held", 16'(key_held), 16'd0);
        check_eq("rst_hex",  {hex3, hex2, hex1, hex0}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        // 1: idle column rotation every 4 clocks
        step(2);  check_eq("t1_col_e2",  16'(col_n), 16'h000E);
        step(4);  check_eq("t1_col_e6",  16'(col_n), 16'h000D);
        step(4);  check_eq("t1_col_e10", 16'(col_n), 16'h000B);
        step(4);  check_eq("t1_col_e14", 16'(col_n), 16'h0007);
        step(4);  check_eq("t1_col_e18", 16'(col_n), 16'h000E);
        check_eq("t1_no_kv", 16'(kv_cnt), 16'd0);
        check_eq("t1_hex",   {hex3, hex2, hex1, hex0}, 16'h0000);

        // 2: row1/col2 held from reset; sample hits at 12,16,20 -> pulse after edge 20
        key_mask = 16'h0040;
        apply_reset();
        step(19); check_eq("t2_kv_e19", 16'(key_valid), 16'd0);
        step(1);  check_eq("t2_kv_e20", 16'(key_valid), 16'd1);
        check_eq("t2_code",   16'(key_code), 16'h0006);
        check_eq("t2_held",   16'(key_held), 16'd1);
        step(1);  check_eq("t2_kv_e21", 16'(key_valid), 16'd0);
        check_eq("t2_hex",    {hex3, hex2, hex1, hex0}, 16'h0006);
        step(40);
        check_eq("t2_held_long", 16'(key_held), 16'd1);
        check_eq("t2_one_pulse", 16'(kv_cnt), 16'd1);
        check_eq("t2_col_frozen", 16'(col_n), 16'h000B);
        key_mask = 16'h0000;
        wait_release(40, "t2_rel_wait");
        check_eq("t2_col_after", 16'(col_n), 16'h0007);

        // 3: enter F,0,A,5
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check_eq("t3_cleared", {hex3, hex2, hex1, hex0}, 16'h0000);
        kv0 = kv_cnt;
        press_key(4'hF);
        press_key(4'h0);
        press_key(4'hA);
        press_key(4'h5);
        check_eq("t3_hex",   {hex3, hex2, hex1, hex0}, 16'hF0A5);
        check_eq("t3_pulses", 16'(kv_cnt - kv0), 16'd4);

        // 4: row3/col0 seen at samples 4 and 8 only, gone for sample 12
        key_mask = 16'h1000;
        kv0 = kv_cnt;
        apply_reset();
        step(9);
        key_mask = 16'h0000;
        step(4);  check_eq("t4_col_e13", 16'(col_n), 16'h000D);
        check_eq("t4_held", 16'(key_held), 16'd0);
        step(5);  check_eq("t4_col_e18", 16'(col_n), 16'h000B);
        check_eq("t4_no_kv", 16'(kv_cnt - kv0), 16'd0);
        check_eq("t4_hex",   {hex3, hex2, hex1, hex0}, 16'h0000);

        // 5: row2/col0, pressed after edge 12; one-sample drop at sample 16
        key_mask = 16'h0100;
        kv0 = kv_cnt;
        apply_reset();
        step(12); check_eq("t5_kv_e12", 16'(key_valid), 16'd1);
        check_eq("t5_code", 16'(key_code), 16'h0008);
        step(1);
        key_mask = 16'h0000;
        check_eq("t5_hex1", {hex3, hex2, hex1, hex0}, 16'h0008);
        step(3);  check_eq("t5_held_rel", 16'(key_held), 16'd1);
        check_eq("t5_col_frozen", 16'(col_n), 16'h000E);
        step(1);
        key_mask = 16'h0100;
        step(4);  check_eq("t5_held_e21", 16'(key_held), 16'd1);
        step(12); check_eq("t5_held_e33", 16'(key_held), 16'd1);
        check_eq("t5_no_second", 16'(kv_cnt - kv0), 16'd1);
        key_mask = 16'h0000;
        wait_release(60, "t5_rel_wait");
        key_mask = 16'h0100;
        wait_kv(80, "t5_repress_wait");
        step(1);
        check_eq("t5_second", 16'(kv_cnt - kv0), 16'd2);
        check_eq("t5_hex2",   {hex3, hex2, hex1, hex0}, 16'h0088);
        key_mask = 16'h0000;
        wait_release(60, "t5_rel2_wait");
        step(5);

        // 6a: clear in the key_valid cycle drops the key
        key_mask = 16'h0020;
        wait_kv(80, "t6_kv_wait");
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check_eq("t6_clear_hex", {hex3, hex2, hex1, hex0}, 16'h0000);
        check_eq("t6_code",      16'(key_code), 16'h0005);

        // 6b: reset while PRESSED, key still held through and after reset
        step(5);
        check_eq("t6_held_pre", 16'(key_held), 16'd1);
        reset = 1'b0;
        #1;
        check_eq("t6_rst_col",  16'(col_n), 16'h000E);
        check_eq("t6_rst_held", 16'(key_held), 16'd0);
        check_eq("t6_rst_code", 16'(key_code), 16'd0);
        check_eq("t6_rst_kv",   16'(key_valid), 16'd0);
        kv0 = kv_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        step(15); check_eq("t6_kv_e15", 16'(key_valid), 16'd0);
        step(1);  check_eq("t6_kv_e16", 16'(key_valid), 16'd1);
        check_eq("t6_code2", 16'(key_code), 16'h0005);
        step(1);
        check_eq("t6_hex",   {hex3, hex2, hex1, hex0}, 16'h0005);
        check_eq("t6_one_new", 16'(kv_cnt - kv0), 16'd1);
        key_mask = 16'h0000;
        step(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
